ram_arbiter: RTL and testbench

//  Shares the single-port 32x8 data RAM between two masters: m0 (CPU datapath) and m1 (loader/IO).

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_rr_arb2.sv | 19 +
 rtl/ram_arbiter.sv | 105 ++++++++++
 tb/tb_ram_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter.
// FSM state encoding and master identifiers.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick.
// The master that did not win last time takes a tie.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       sel_o
);

  always_comb begin
    sel_o = M0;
    if (&req_i)
      sel_o = ~last_i;
    else if (req_i[1])
      sel_o = M1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between m0 and m1.
// Round-robin, fixed three-cycle IDLE/SERVE/ACK access.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_i,
  input  logic          m0_wen_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_din_i,
  output logic          m0_ack_o,
  output logic [DW-1:0] m0_dout_o,
  input  logic          m1_req_i,
  input  logic          m1_wen_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_din_i,
  output logic          m1_ack_o,
  output logic [DW-1:0] m1_dout_o,
  output logic          ram_wen_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);

  state_e        state_q;
  logic          last_q;
  logic          sel_q;
  logic          wen_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] dout_q;
  logic          m0_ack_q, m1_ack_q;
  logic [DW-1:0] m0_dout_q, m1_dout_q;

  logic          sel_d;
  logic [DW-1:0] rd_d;

  rr_arb2 u_arb (
    .req_i  ({m1_req_i, m0_req_i}),
    .last_i (last_q),
    .sel_o  (sel_d)
  );

  // After a write the returned data is a don't-care, so reuse dout_q.
  assign rd_d = wen_q ? dout_q : ram_dout_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= M1;
      sel_q     <= M0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m0_dout_q <= '0;
      m1_dout_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m0_req_i | m1_req_i) begin
            sel_q   <= sel_d;
            wen_q   <= sel_d ? m1_wen_i  : m0_wen_i;
            addr_q  <= sel_d ? m1_addr_i : m0_addr_i;
            din_q   <= sel_d ? m1_din_i  : m0_din_i;
            state_q <= SERVE;
          end
        end
        SERVE: begin
          if (!wen_q)
            dout_q <= ram_dout_i;
          last_q    <= sel_q;
          m0_ack_q  <= (sel_q == M0);
          m1_ack_q  <= (sel_q == M1);
          m0_dout_q <= (sel_q == M0) ? rd_d : '0;
          m1_dout_q <= (sel_q == M1) ? rd_d : '0;
          state_q   <= ACK;
        end
        ACK: begin
          m0_ack_q  <= 1'b0;
          m1_ack_q  <= 1'b0;
          m0_dout_q <= '0;
          m1_dout_q <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_wen_o  = (state_q == SERVE) & wen_q & ~rst_i;
  assign ram_addr_o = addr_q;
  assign ram_din_o  = din_q;
  assign m0_ack_o   = m0_ack_q;
  assign m1_ack_o   = m1_ack_q;
  assign m0_dout_o  = m0_dout_q;
  assign m1_dout_o  = m1_dout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32x8 RAM.
// RAM word i powers up as i*7+3.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_req, m0_wen, m1_req, m1_wen;
  logic [4:0] m0_addr, m1_addr;
  logic [7:0] m0_din, m1_din;
  logic       m0_ack, m1_ack;
  logic [7:0] m0_dout, m1_dout;
  logic       ram_wen;
  logic [4:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  logic [7:0] mem [32];
  int         n_run = 0;
  int         n_fail = 0;
  int         wen_cnt = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(5), .DW(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m0_req_i   (m0_req),
    .m0_wen_i   (m0_wen),
    .m0_addr_i  (m0_addr),
    .m0_din_i   (m0_din),
    .m0_ack_o   (m0_ack),
    .m0_dout_o  (m0_dout),
    .m1_req_i   (m1_req),
    .m1_wen_i   (m1_wen),
    .m1_addr_i  (m1_addr),
    .m1_din_i   (m1_din),
    .m1_ack_o   (m1_ack),
    .m1_dout_o  (m1_dout),
    .ram_wen_o  (ram_wen),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_wen) begin
      mem[ram_addr] <= ram_din;
      wen_cnt <= wen_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input bit m, input bit w, input logic [4:0] a,
                        input logic [7:0] d, input bit chg,
                        input logic [4:0] a2,
                        output logic [7:0] rd, output int lat);
    lat = -1;
    rd = '0;
    @(negedge clk);
    if (!m) begin
      m0_req = 1; m0_wen = w; m0_addr = a; m0_din = d;
    end else begin
      m1_req = 1; m1_wen = w; m1_addr = a; m1_din = d;
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1 && chg) begin
        if (!m) m0_addr = a2;
        else    m1_addr = a2;
      end
      if ((!m && m0_ack) || (m && m1_ack)) begin
        rd = m ? m1_dout : m0_dout;
        lat = i;
        m0_req = 0;
        m1_req = 0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    m0_req = 0;
    m1_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  logic [7:0] rd;
  int         lat, w0, a0, a1, t, last_t, last_m, n0, n1;
  bit         bad_alt, bad_gap;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);
    rst = 1;
    m0_req = 0; m0_wen = 0; m0_addr = '0; m0_din = '0;
    m1_req = 0; m1_wen = 0; m1_addr = '0; m1_din = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    wen_cnt = 0;

    // 1: idle after reset
    a0 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack || m0_dout != 0 || m1_dout != 0) a0++;
    end
    chk("idle_quiet", a0, 0);
    chk("idle_no_wen", wen_cnt, 0);

    // 2: write then read back
    w0 = wen_cnt;
    do_txn(0, 1, 5'h03, 8'hA5, 0, 5'h00, rd, lat);
    chk("wr_lat", lat, 2);
    chk("wr_wen_once", wen_cnt - w0, 1);
    w0 = wen_cnt;
    do_txn(0, 0, 5'h03, 8'h00, 0, 5'h00, rd, lat);
    chk("rd_lat", lat, 2);
    chk("rd_data", rd, 8'hA5);
    chk("rd_no_wen", wen_cnt - w0, 0);
    @(negedge clk);
    chk("dout_zero_after", m0_dout, 8'h00);

    // 3: simultaneous requests after reset
    do_reset();
    @(negedge clk);
    m0_req = 1; m0_wen = 0; m0_addr = 5'h00;
    m1_req = 1; m1_wen = 0; m1_addr = 5'h1F;
    a0 = -1; a1 = -1;
    for (int i = 1; i <= 12 && a1 < 0; i++) begin
      @(negedge clk);
      if (m0_ack && a0 < 0) begin
        a0 = i;
        chk("tie_m0_data", m0_dout, 8'h03);
        m0_req = 0;
      end
      if (m1_ack && a1 < 0) begin
        a1 = i;
        chk("tie_m1_data", m1_dout, 8'hDC);
        m1_req = 0;
      end
    end
    m0_req = 0; m1_req = 0;
    chk("tie_m0_first", a0, 2);
    chk("tie_m1_later", a1, 5);

    // 4: sustained contention
    @(negedge clk);
    @(negedge clk);
    m0_req = 1; m0_wen = 0; m0_addr = 5'h04;
    m1_req = 1; m1_wen = 0; m1_addr = 5'h05;
    n0 = 0; n1 = 0; last_t = -1; last_m = 1;
    bad_alt = 0; bad_gap = 0;
    for (t = 1; t <= 40 && (n0 < 4 || n1 < 4); t++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        if (last_t >= 0 && t - last_t != 3) bad_gap = 1;
        if ((m0_ack ? 0 : 1) == last_m) bad_alt = 1;
        if (m0_ack && m1_ack) bad_alt = 1;
        last_m = m0_ack ? 0 : 1;
        last_t = t;
        if (m0_ack) begin
          n0++;
          if (m0_dout != 8'h1F) bad_alt = 1;
          if (n0 == 4) m0_req = 0;
        end
        if (m1_ack) begin
          n1++;
          if (m1_dout != 8'h26) bad_alt = 1;
          if (n1 == 4) m1_req = 0;
        end
      end
    end
    chk("rr_m0_count", n0, 4);
    chk("rr_m1_count", n1, 4);
    chk("rr_alternate", bad_alt, 0);
    chk("rr_spacing", bad_gap, 0);

    // 5: reset during SERVE of an m1 write
    @(negedge clk);
    @(negedge clk);
    w0 = wen_cnt;
    m1_req = 1; m1_wen = 1; m1_addr = 5'h10; m1_din = 8'h5A;
    @(negedge clk);
    rst = 1;
    m1_req = 0;
    #1;
    chk("rst_wen_gated", ram_wen, 0);
    a1 = 0;
    @(negedge clk);
    if (m1_ack) a1++;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m1_ack) a1++;
    end
    chk("rst_no_ack", a1, 0);
    chk("rst_no_write", wen_cnt - w0, 0);
    do_txn(0, 0, 5'h10, 8'h00, 0, 5'h00, rd, lat);
    chk("rst_idle_lat", lat, 2);
    chk("rst_prior_data", rd, 8'h73);

    // 6: address change after the IDLE latch
    do_txn(0, 1, 5'h01, 8'h77, 1, 5'h02, rd, lat);
    chk("chg_wr_lat", lat, 2);
    do_txn(0, 0, 5'h01, 8'h00, 0, 5'h00, rd, lat);
    chk("chg_rd_01", rd, 8'h77);
    do_txn(0, 0, 5'h02, 8'h00, 0, 5'h00, rd, lat);
    chk("chg_rd_02", rd, 8'h11);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
